// File: rtl/not_chk_pkg.sv
// Shared types and limits for the not_4b response checker.
package not_chk_pkg;

  localparam int unsigned LAT_MAX = 3;
  localparam int unsigned DRAIN_W = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/not_4b_checker_exp_delay.sv
// exp_delay: LAT-deep shift register of {valid, data} with synchronous clear.
// Degenerates to a pass-through when LAT is 0.
module exp_delay #(
  parameter int unsigned LAT = 0,
  parameter int unsigned DW  = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  generate
    if (LAT == 0) begin : g_pass
      logic unused_lat0;
      assign unused_lat0 = clk ^ clr;
      assign out_valid   = in_valid;
      assign out_data    = in_data;
    end else begin : g_shift
      logic [LAT-1:0] valid_q, valid_d;
      logic [DW-1:0]  data_q [LAT];
      logic [DW-1:0]  data_d [LAT];

      // Stage 0 takes the new entry, later stages shift by one.
      always_comb begin
        valid_d[0] = in_valid;
        data_d[0]  = in_data;
        for (int i = 1; i < int'(LAT); i++) begin
          valid_d[i] = valid_q[i-1];
          data_d[i]  = data_q[i-1];
        end
        if (clr) begin
          valid_d = '0;
          for (int i = 0; i < int'(LAT); i++) data_d[i] = '0;
        end
      end

      always_ff @(posedge clk) begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end

      assign out_valid = valid_q[LAT-1];
      assign out_data  = data_q[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/not_4b_checker.sv
// Response checker for not_4b: compares DUT responses against ~stim delayed by LAT.
// Define FIRST_FAIL_EN to capture the stimulus/response of the first mismatch.
module not_4b_checker
  import not_chk_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LAT   = 0,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] stim,
  input  logic [WIDTH-1:0] resp,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [WIDTH-1:0] first_fail_stim,
  output logic [WIDTH-1:0] first_fail_resp
);

`ifdef FIRST_FAIL_EN
  localparam int unsigned DW = 2 * WIDTH;
`else
  localparam int unsigned DW = WIDTH;
`endif
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [CNT_W-1:0]   pass_q, pass_d, fail_q, fail_d;

  logic               push_valid;
  logic [DW-1:0]      push_data;
  logic               cmp_valid;
  logic [DW-1:0]      cmp_data;
  logic [WIDTH-1:0]   cmp_exp;
  logic               mismatch;
  logic               start_run;

  assign push_valid = (state_q == S_RUN) && in_valid;
`ifdef FIRST_FAIL_EN
  assign push_data  = {~stim, stim};
`else
  assign push_data  = ~stim;
`endif

  exp_delay #(.LAT(LAT), .DW(DW)) u_exp_delay (
    .clk       (clk),
    .clr       (rst),
    .in_valid  (push_valid),
    .in_data   (push_data),
    .out_valid (cmp_valid),
    .out_data  (cmp_data)
  );

  assign cmp_exp   = cmp_data[DW-1 -: WIDTH];
  assign mismatch  = cmp_valid && (resp != cmp_exp);
  assign start_run = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;

  // Next state, drain countdown and saturating scoreboard counters.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          pass_d  = '0;
          fail_d  = '0;
          err_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (stop) begin
          if (LAT == 0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DRAIN;
            drain_d = DRAIN_W'(LAT - 1);
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) state_d = S_DONE;
        else               drain_d = drain_q - DRAIN_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    if (cmp_valid) begin
      if (mismatch) begin
        err_d = 1'b1;
        if (fail_q != CNT_MAX) fail_d = fail_q + CNT_W'(1);
      end else if (pass_q != CNT_MAX) begin
        pass_d = pass_q + CNT_W'(1);
      end
    end

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      pass_q  <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;

`ifdef FIRST_FAIL_EN
  logic [WIDTH-1:0] ffs_q, ffs_d, ffr_q, ffr_d;

  // Capture only the first mismatch of a run; err_q marks that one was seen.
  always_comb begin
    ffs_d = ffs_q;
    ffr_d = ffr_q;
    if (start_run) begin
      ffs_d = '0;
      ffr_d = '0;
    end else if (mismatch && !err_q) begin
      ffs_d = cmp_data[WIDTH-1:0];
      ffr_d = resp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ffs_q <= '0;
      ffr_q <= '0;
    end else begin
      ffs_q <= ffs_d;
      ffr_q <= ffr_d;
    end
  end

  assign first_fail_stim = ffs_q;
  assign first_fail_resp = ffr_q;
`else
  logic unused_start_run;
  assign unused_start_run = start_run;
  assign first_fail_stim  = '0;
  assign first_fail_resp  = '0;
`endif

endmodule

// File: tb/tb_not_4b_checker.sv
// Scoreboard bench for not_4b_checker: three instances (LAT=0, LAT=2, CNT_W=2).
module tb_not_4b_checker;

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] fc;
    logic       err;
    logic [3:0] ffs;
    logic [3:0] ffr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_s [3];
  logic       stop_s  [3];
  logic       iv_s    [3];
  logic [3:0] stim_s  [3];
  logic [3:0] resp_s  [3];

  logic       busy0, busy1, busy2, done0, done1, done2, err0, err1, err2;
  logic [7:0] pc0, pc1, fc0, fc1;
  logic [1:0] pc2, fc2;
  logic [3:0] ffs0, ffs1, ffs2, ffr0, ffr1, ffr2;

  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t q0[$], q1[$], q2[$];
  logic dprev0 = 1'b0, dprev1 = 1'b0, dprev2 = 1'b0;

  not_4b_checker #(.WIDTH(4), .LAT(0), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .stop(stop_s[0]), .in_valid(iv_s[0]),
    .stim(stim_s[0]), .resp(resp_s[0]), .busy(busy0), .done(done0), .err(err0),
    .pass_cnt(pc0), .fail_cnt(fc0), .first_fail_stim(ffs0), .first_fail_resp(ffr0));

  not_4b_checker #(.WIDTH(4), .LAT(2), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .stop(stop_s[1]), .in_valid(iv_s[1]),
    .stim(stim_s[1]), .resp(resp_s[1]), .busy(busy1), .done(done1), .err(err1),
    .pass_cnt(pc1), .fail_cnt(fc1), .first_fail_stim(ffs1), .first_fail_resp(ffr1));

  not_4b_checker #(.WIDTH(4), .LAT(0), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .start(start_s[2]), .stop(stop_s[2]), .in_valid(iv_s[2]),
    .stim(stim_s[2]), .resp(resp_s[2]), .busy(busy2), .done(done2), .err(err2),
    .pass_cnt(pc2), .fail_cnt(fc2), .first_fail_stim(ffs2), .first_fail_resp(ffr2));

  function automatic logic [7:0] g_pc(int i);
    case (i) 0: return pc0; 1: return pc1; default: return {6'b0, pc2}; endcase
  endfunction
  function automatic logic [7:0] g_fc(int i);
    case (i) 0: return fc0; 1: return fc1; default: return {6'b0, fc2}; endcase
  endfunction
  function automatic logic g_busy(int i);
    case (i) 0: return busy0; 1: return busy1; default: return busy2; endcase
  endfunction
  function automatic logic g_done(int i);
    case (i) 0: return done0; 1: return done1; default: return done2; endcase
  endfunction
  function automatic logic g_err(int i);
    case (i) 0: return err0; 1: return err1; default: return err2; endcase
  endfunction
  function automatic logic [3:0] g_ffs(int i);
    case (i) 0: return ffs0; 1: return ffs1; default: return ffs2; endcase
  endfunction
  function automatic logic [3:0] g_ffr(int i);
    case (i) 0: return ffr0; 1: return ffr1; default: return ffr2; endcase
  endfunction

  task automatic chk(input string name, input int i, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[u%0d]: got %0h, expected %0h", name, i, act, exp);
    end
  endtask

  task automatic push_exp(input int i, input logic [7:0] pc, input logic [7:0] fc,
                          input logic e, input logic [3:0] ffs, input logic [3:0] ffr);
    exp_t x;
    x.pc = pc; x.fc = fc; x.err = e;
`ifdef FIRST_FAIL_EN
    x.ffs = ffs; x.ffr = ffr;
`else
    x.ffs = 4'h0; x.ffr = 4'h0;
    if (ffs != ffr) x.ffs = 4'h0;
`endif
    case (i) 0: q0.push_back(x); 1: q1.push_back(x); default: q2.push_back(x); endcase
  endtask

  task automatic pop_cmp(input int i);
    exp_t x;
    int   sz;
    sz = (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
    chk("sb_pending", i, 8'(sz != 0), 8'd1);
    if (sz != 0) begin
      case (i) 0: x = q0.pop_front(); 1: x = q1.pop_front(); default: x = q2.pop_front(); endcase
      chk("sb_pass_cnt", i, g_pc(i), x.pc);
      chk("sb_fail_cnt", i, g_fc(i), x.fc);
      chk("sb_err", i, 8'(g_err(i)), 8'(x.err));
      chk("sb_ff_stim", i, 8'(g_ffs(i)), 8'(x.ffs));
      chk("sb_ff_resp", i, 8'(g_ffr(i)), 8'(x.ffr));
    end
  endtask

  // Monitor: a rising done presents the final counts of a run.
  always @(negedge clk) begin
    if (done0 && !dprev0) pop_cmp(0);
    if (done1 && !dprev1) pop_cmp(1);
    if (done2 && !dprev2) pop_cmp(2);
    dprev0 <= done0;
    dprev1 <= done1;
    dprev2 <= done2;
  end

  task automatic drv(input int i, input logic st, input logic sp, input logic v,
                     input logic [3:0] s, input logic [3:0] r);
    start_s[i] = st; stop_s[i] = sp; iv_s[i] = v; stim_s[i] = s; resp_s[i] = r;
    @(negedge clk);
  endtask

  task automatic idle(input int i);
    drv(i, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
  endtask

  task automatic wait_done(input int i);
    for (int k = 0; k < 10 && !g_done(i); k++) @(negedge clk);
    chk("done_timeout", i, 8'(g_done(i)), 8'd1);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0; stop_s[i] = 1'b0; iv_s[i] = 1'b0; stim_s[i] = 4'h0; resp_s[i] = 4'h0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", i, 8'(g_busy(i)), 8'd0);
      chk("rst_done", i, 8'(g_done(i)), 8'd0);
      chk("rst_err", i, 8'(g_err(i)), 8'd0);
      chk("rst_pass", i, g_pc(i), 8'd0);
      chk("rst_fail", i, g_fc(i), 8'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // LAT=0: three good vectors, done one cycle after stop.
    drv(0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("run_busy", 0, 8'(busy0), 8'd1);
    drv(0, 1'b0, 1'b0, 1'b1, 4'b1000, 4'b0111);
    drv(0, 1'b0, 1'b0, 1'b1, 4'b1101, 4'b0010);
    drv(0, 1'b0, 1'b0, 1'b1, 4'b0101, 4'b1010);
    push_exp(0, 8'd3, 8'd0, 1'b0, 4'h0, 4'h0);
    drv(0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    chk("done_lat0", 0, 8'(done0), 8'd1);
    chk("busy_done", 0, 8'(busy0), 8'd0);
    idle(0);

    // LAT=0: one pass then two faults; the first fault is captured.
    drv(0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    drv(0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b1111);
    drv(0, 1'b0, 1'b0, 1'b1, 4'b0011, 4'b1111);
    drv(0, 1'b0, 1'b0, 1'b1, 4'b0001, 4'b0000);
    push_exp(0, 8'd1, 8'd2, 1'b1, 4'b0011, 4'b1111);
    drv(0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    wait_done(0);
    idle(0);

    // DONE with start and stop together: start wins.
    drv(0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
    chk("ss_busy", 0, 8'(busy0), 8'd1);
    chk("ss_done", 0, 8'(done0), 8'd0);
    chk("ss_pass", 0, pc0, 8'd0);
    chk("ss_fail", 0, fc0, 8'd0);
    chk("ss_err", 0, 8'(err0), 8'd0);
    drv(0, 1'b0, 1'b0, 1'b1, 4'b1111, 4'b0000);
    push_exp(0, 8'd1, 8'd0, 1'b0, 4'h0, 4'h0);
    drv(0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    wait_done(0);
    idle(0);

    // LAT=2: response arrives two cycles later, stop while in flight.
    drv(1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    drv(1, 1'b0, 1'b0, 1'b1, 4'b1010, 4'b1111);
    drv(1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1111);
    push_exp(1, 8'd1, 8'd0, 1'b0, 4'h0, 4'h0);
    drv(1, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0101);
    chk("drain_busy", 1, 8'(busy1), 8'd1);
    chk("drain_done", 1, 8'(done1), 8'd0);
    drv(1, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
    chk("done_lat2", 1, 8'(done1), 8'd1);
    idle(1);
    chk("done_hold_pass", 1, pc1, 8'd1);

    // CNT_W=2: six passing vectors saturate at 3.
    drv(2, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    for (int k = 0; k < 6; k++) begin
      logic [3:0] s;
      s = 4'(k * 3 + 1);
      drv(2, 1'b0, 1'b0, 1'b1, s, ~s);
    end
    chk("sat_pass", 2, {6'b0, pc2}, 8'd3);
    push_exp(2, 8'd3, 8'd0, 1'b0, 4'h0, 4'h0);
    drv(2, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    wait_done(2);
    idle(2);

    // rst mid-RUN overrides start; in_valid ignored afterwards in IDLE.
    drv(0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    drv(0, 1'b0, 1'b0, 1'b1, 4'b1010, 4'b0101);
    drv(0, 1'b0, 1'b0, 1'b1, 4'b0110, 4'b1001);
    chk("pre_rst_pass", 0, pc0, 8'd2);
    rst = 1'b1;
    drv(0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000);
    rst = 1'b0;
    chk("mid_rst_busy", 0, 8'(busy0), 8'd0);
    chk("mid_rst_done", 0, 8'(done0), 8'd0);
    chk("mid_rst_pass", 0, pc0, 8'd0);
    chk("mid_rst_fail", 0, fc0, 8'd0);
    drv(0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
    drv(0, 1'b0, 1'b0, 1'b1, 4'b0101, 4'b1010);
    chk("idle_busy", 0, 8'(busy0), 8'd0);
    chk("idle_pass", 0, pc0, 8'd0);
    chk("idle_fail", 0, fc0, 8'd0);
    chk("idle_err", 0, 8'(err0), 8'd0);
    idle(0);

    chk("sb_leftover", 0, 8'(q0.size() + q1.size() + q2.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/not_4b_checker.md
# not_4b_checker

Synthesizable response checker for the consuming end of the not_4b stimulus stream. It accepts stimulus vectors and the inverter's responses, forms the expected value (bitwise inverse of the stimulus), and aligns it to a configurable DUT latency. It compares each response, keeps pass/fail counts, and reports completion. It sits beside not_4b (or a pipelined variant) in simulation benches and on-board self-test wrappers.

## Interface
- WIDTH, 4, vector width
- LAT, 0, DUT latency in cycles, legal 0..3
- CNT_W, 8, width of pass/fail counters
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a run; clears counters
- stop  input  1  end a run; drain in-flight vectors
- in_valid  input  1  stim is valid this cycle
- stim  input  WIDTH  stimulus applied to DUT
- resp  input  WIDTH  DUT output
- busy  output  1  high in RUN or DRAIN
- done  output  1  high in DONE
- err  output  1  sticky; any mismatch this run
- pass_cnt  output  CNT_W  matching responses, saturating
- fail_cnt  output  CNT_W  mismatching responses, saturating
- first_fail_stim  output  WIDTH  stim of first failing vector (FIRST_FAIL_EN only)
- first_fail_resp  output  WIDTH  resp of first failing vector (FIRST_FAIL_EN only)

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- Reset: state IDLE. All outputs 0. Delay line cleared.
- IDLE: start -> RUN. Counters, err and capture regs cleared on the same edge. stop and in_valid are ignored.
- RUN: each in_valid cycle pushes {1, ~stim} into an LAT-deep delay line. A slot with valid=0 is pushed otherwise. stop -> DRAIN. start is ignored.
- DRAIN: in_valid is ignored and 0s are pushed. After LAT cycles (0 cycles if LAT=0, i.e. straight to DONE) the state becomes DONE.
- DONE: counts and err are held. start -> RUN with cleared counters. stop is ignored.
- start and stop both high in IDLE or DONE: start wins; stop is ignored in that cycle.
- Compare: when the delay-line output valid=1 (LAT=0: in_valid itself, in RUN only), resp is compared to the expected value.
  - Equal: pass_cnt+1.
  - Unequal: fail_cnt+1 and err set.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Compares emerging during DRAIN are counted. Compares during IDLE/DONE never occur.
- rst at any time, including mid-RUN or mid-DRAIN, returns to reset values on the next edge. It overrides start.

## Timing
- Vector accepted at edge n (in_valid high in cycle n): resp is sampled in cycle n+LAT. The counter/err update is visible after edge n+LAT.
- LAT=0: stim and resp are presented in the same cycle. Counts are visible the next cycle.
- stop sampled at edge m: busy stays high through DRAIN. done rises after edge m+LAT (m for LAT=0) plus 1 state transition. The final count is stable when done=1.
- Throughput: one vector per cycle, no back-pressure.

## Configuration
- FIRST_FAIL_EN defined:
  - first_fail_stim/resp capture the stimulus and response of the first mismatch after start.
  - Later mismatches do not overwrite them.
  - They are cleared by start and rst.
  - The delay line also carries the raw stim.
- FIRST_FAIL_EN undefined: the capture registers and the raw-stim delay path are removed, and first_fail_stim/resp are tied to 0.

## Structure
- Package not_chk_pkg holds:
  - state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DRAIN=2'd2, S_DONE=2'd3
  - LAT_MAX=3
- Sub-module exp_delay: parameterized depth-LAT shift register of {valid, expected[, stim]} with synchronous clear. A pass-through when LAT=0.
- Top holds the FSM, drain counter, comparator, saturating counters and capture regs.

## Test plan
- LAT=0. start, then stim 1000/1101/0101 with resp 0111/0010/1010, then stop -> pass_cnt=3, fail_cnt=0, err=0, done=1 one cycle after stop.
- LAT=0. stim 0000 with resp 1111 correct, then stim 0011 with faulty resp 1111 -> pass_cnt=1, fail_cnt=1, err=1. With FIRST_FAIL_EN: first_fail_stim=0011, first_fail_resp=1111.
- LAT=2. stim 1010 at cycle n, resp 0101 at n+2 and garbage 1111 at n, n+1; stop at n+1 -> pass_cnt=1, fail_cnt=0, done after drain completes.
- CNT_W=2. Six passing vectors -> pass_cnt saturates at 3 and stays there.
- rst pulsed mid-RUN with pass_cnt=2 -> next cycle busy=0, done=0, counts 0, state IDLE. in_valid is ignored until start.
- In DONE, start with stop also high -> counts cleared and state RUN. A subsequent stim 1111 with resp 0000 -> pass_cnt=1.
